// File: rtl/sif_frame_gate_pkg.sv
// Shared types and constants for the sensor-interface frame gate.
package sif_frame_gate_pkg;

  // Frame gate states: waiting for a start of frame, forwarding one, or discarding the remainder.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StDrop = 2'd2
  } gate_state_e;

  // Bit positions within the AXIS tuser field.
  localparam int unsigned TUSER_SOF_BIT   = 0;
  localparam int unsigned TUSER_TRUNC_BIT = 1;

  // Control portion of a FIFO entry; data and keep widths are set by the top-level parameters,
  // so the top wraps this in the full entry struct.
  typedef struct packed {
    logic last;
    logic sof;
    logic trunc;
  } entry_ctl_t;

  localparam int unsigned EntryCtlW = $bits(entry_ctl_t);

  // Saturating increment for the 16-bit dropped-frame counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/sif_frame_gate_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Writes to a full FIFO and reads from an empty one are ignored.
module sif_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic            rd_en_i,
  output logic            rd_valid_o,
  output logic [Width-1:0] rd_data_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty, push, pop;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign push  = wr_en_i && !full;
  assign pop   = rd_en_i && !empty;

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because the read side is qualified by occupancy.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/sif_frame_gate.sv
// Frame gate between a free-running sensor pixel stream and the AXIS sensor interface input.
// Frames are buffered in a small FIFO; when the FIFO is about to overflow the current line is
// closed with a truncation marker and the rest of the frame is discarded.
// Optional line-length checker enabled by defining SIF_FRAME_GATE_LINE_CHECK_EN.
module sif_frame_gate
  import sif_frame_gate_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned KEEP_W     = 8,
  parameter int unsigned USER_W     = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LINE_LEN_W = 16
) (
  input  logic                  i_sif_clk,
  input  logic                  i_sif_rst_n,
  input  logic                  i_enable,
  input  logic                  i_pix_vld,
  input  logic [DATA_W-1:0]     i_pix_data,
  input  logic [KEEP_W-1:0]     i_pix_keep,
  input  logic                  i_pix_sof,
  input  logic                  i_pix_eol,
  input  logic                  i_pix_eof,
  input  logic [LINE_LEN_W-1:0] i_line_len,
  output logic                  o_sif_axis_tvalid,
  output logic                  o_sif_axis_tlast,
  output logic [DATA_W-1:0]     o_sif_axis_tdata,
  output logic [KEEP_W-1:0]     o_sif_axis_tkeep,
  output logic [USER_W-1:0]     o_sif_axis_tuser,
  input  logic                  i_sif_axis_tready,
  output logic                  o_frame_active,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_cnt,
  output logic                  o_len_err
);

  localparam int unsigned EntryW = DATA_W + KEEP_W + EntryCtlW;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  // Highest occupancy at which a mid-frame beat may still be written; that write closes the line
  // as truncated so one slot always stays free.
  localparam logic [CntW-1:0] LimitCnt = CntW'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    entry_ctl_t        ctl;
  } entry_t;

  logic [1:0]      rst_sync_q;
  logic            rst_n;
  gate_state_e     state_q, state_d;
  entry_t          wr_entry, rd_entry;
  logic [EntryW-1:0] rd_data;
  logic            wr_en, rd_valid;
  logic [CntW-1:0] fifo_count;
  logic            at_limit, start_blocked, beat_last;
  logic            overflow_d, overflow_q;
  logic [15:0]     drop_cnt_d, drop_cnt_q;

  // Reset synchroniser: assertion is immediate, release is aligned to the clock.
  always_ff @(posedge i_sif_clk or negedge i_sif_rst_n) begin
    if (!i_sif_rst_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  assign at_limit      = (fifo_count == LimitCnt);
  assign start_blocked = (fifo_count > LimitCnt);
  assign beat_last     = i_pix_eol | i_pix_eof;

  // Gate FSM next state and FIFO write control.
  always_comb begin
    state_d            = state_q;
    wr_en              = 1'b0;
    overflow_d         = 1'b0;
    wr_entry.data      = i_pix_data;
    wr_entry.keep      = i_pix_keep;
    wr_entry.ctl.last  = beat_last;
    wr_entry.ctl.sof   = i_pix_sof;
    wr_entry.ctl.trunc = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_pix_vld && i_pix_sof && i_enable) begin
          if (start_blocked) begin
            // No room for even one beat of the new frame: drop it whole.
            overflow_d = 1'b1;
            if (!i_pix_eof) state_d = StDrop;
          end else if (at_limit && !i_pix_eof) begin
            wr_en              = 1'b1;
            wr_entry.ctl.last  = 1'b1;
            wr_entry.ctl.trunc = 1'b1;
            overflow_d         = 1'b1;
            state_d            = StDrop;
          end else begin
            wr_en = 1'b1;
            if (!i_pix_eof) state_d = StPass;
          end
        end
      end
      StPass: begin
        if (i_pix_vld) begin
          wr_en = 1'b1;
          if (at_limit && !i_pix_eof) begin
            wr_entry.ctl.last  = 1'b1;
            wr_entry.ctl.trunc = 1'b1;
            overflow_d         = 1'b1;
            state_d            = StDrop;
          end else if (i_pix_eof) begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (i_pix_vld && i_pix_eof) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign drop_cnt_d = overflow_d ? sat_inc16(drop_cnt_q) : drop_cnt_q;

  // State, overflow pulse and dropped-frame counter registers.
  always_ff @(posedge i_sif_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sif_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_sif_clk),
    .rst_ni     (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_entry),
    .rd_en_i    (i_sif_axis_tready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .count_o    (fifo_count)
  );

  assign rd_entry = entry_t'(rd_data);

  // AXIS outputs; payload is forced to zero while nothing is queued.
  always_comb begin
    o_sif_axis_tvalid = rd_valid;
    o_sif_axis_tlast  = 1'b0;
    o_sif_axis_tdata  = '0;
    o_sif_axis_tkeep  = '0;
    o_sif_axis_tuser  = '0;
    if (rd_valid) begin
      o_sif_axis_tlast                  = rd_entry.ctl.last;
      o_sif_axis_tdata                  = rd_entry.data;
      o_sif_axis_tkeep                  = rd_entry.keep;
      o_sif_axis_tuser[TUSER_SOF_BIT]   = rd_entry.ctl.sof;
      o_sif_axis_tuser[TUSER_TRUNC_BIT] = rd_entry.ctl.trunc;
    end
  end

  assign o_frame_active = (state_q == StPass);
  assign o_overflow     = overflow_q;
  assign o_drop_cnt     = drop_cnt_q;

`ifdef SIF_FRAME_GATE_LINE_CHECK_EN
  logic [LINE_LEN_W-1:0] line_cnt_q, line_cnt_d, line_base;
  logic [LINE_LEN_W:0]   line_beats;
  logic                  len_err_d, len_err_q;

  // Per-line written-beat counter; flags lines whose length differs from i_line_len.
  always_comb begin
    line_cnt_d = line_cnt_q;
    len_err_d  = 1'b0;
    line_base  = wr_entry.ctl.sof ? '0 : line_cnt_q;
    line_beats = {1'b0, line_base} + (LINE_LEN_W + 1)'(1);
    if (wr_en) begin
      if (wr_entry.ctl.trunc) begin
        line_cnt_d = '0;
      end else if (beat_last) begin
        line_cnt_d = '0;
        if (line_beats != {1'b0, i_line_len}) len_err_d = 1'b1;
      end else if (&line_base) begin
        // Counter would wrap: hold it at its maximum.
        len_err_d  = 1'b1;
        line_cnt_d = line_base;
      end else begin
        line_cnt_d = line_beats[LINE_LEN_W-1:0];
      end
    end
  end

  // Line counter and error pulse registers.
  always_ff @(posedge i_sif_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      line_cnt_q <= line_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign o_len_err = len_err_q;
`else
  logic unused_line_len;
  assign unused_line_len = ^i_line_len;
  assign o_len_err       = 1'b0;
`endif

  // A write must never land on a full FIFO.
  assert property (@(posedge i_sif_clk) disable iff (!rst_n) !(wr_en && fifo_count == DepthCnt));

endmodule

// File: tb/tb_sif_frame_gate.sv
// Self-checking bench for sif_frame_gate with a queue-based reference model.
module tb_sif_frame_gate;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 2;
  localparam int D  = 16;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          pix_vld = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [KW-1:0] pix_keep = '0;
  logic          pix_sof = 1'b0;
  logic          pix_eol = 1'b0;
  logic          pix_eof = 1'b0;
  logic [LW-1:0] line_len = LW'(4);
  logic          tvalid, tlast, tready = 1'b0;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          frame_active, overflow, len_err;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  sif_frame_gate #(
    .DATA_W     (DW),
    .KEEP_W     (KW),
    .USER_W     (UW),
    .FIFO_DEPTH (D),
    .LINE_LEN_W (LW)
  ) dut (
    .i_sif_clk         (clk),
    .i_sif_rst_n       (rst_n),
    .i_enable          (enable),
    .i_pix_vld         (pix_vld),
    .i_pix_data        (pix_data),
    .i_pix_keep        (pix_keep),
    .i_pix_sof         (pix_sof),
    .i_pix_eol         (pix_eol),
    .i_pix_eof         (pix_eof),
    .i_line_len        (line_len),
    .o_sif_axis_tvalid (tvalid),
    .o_sif_axis_tlast  (tlast),
    .o_sif_axis_tdata  (tdata),
    .o_sif_axis_tkeep  (tkeep),
    .o_sif_axis_tuser  (tuser),
    .i_sif_axis_tready (tready),
    .o_frame_active    (frame_active),
    .o_overflow        (overflow),
    .o_drop_cnt        (drop_cnt),
    .o_len_err         (len_err)
  );

  int passed = 0;
  int total  = 0;

  // Monitor state.
  beat_t act_q[$];
  int    cyc = 0;
  int    first_vld_cyc = -1;
  int    ovf_seen = 0;
  int    lerr_seen = 0;
  bit    active_seen = 1'b0;

  // Reference model state.
  beat_t exp_q[$];
  int    m_occ = 0;
  bit    m_in_frame = 1'b0;
  bit    m_dropping = 1'b0;
  int    m_drops = 0;
  int    m_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && tready) act_q.push_back(beat_t'({tdata, tkeep, tlast, tuser}));
    if (tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (overflow) ovf_seen++;
    if (len_err) lerr_seen++;
    if (frame_active) active_seen = 1'b1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // One input cycle plus the matching model update. The model keeps only an occupancy figure
  // and the ordered list of beats the gate should emit.
  task automatic drive(input bit vld, input bit sof, input bit eol, input bit eof,
                       input bit en, input bit rdy);
    beat_t e;
    bit    pop;
    bit    wr;
    pix_vld  = vld;
    pix_sof  = sof;
    pix_eol  = eol;
    pix_eof  = eof;
    enable   = en;
    tready   = rdy;
    pix_data = {$urandom(), $urandom()};
    pix_keep = KW'($urandom_range(1, 255));
    e.data = pix_data;
    e.keep = pix_keep;
    e.last = eol | eof;
    e.user = {1'b0, sof};
    pop = (m_occ > 0) && rdy;
    wr  = 1'b0;
    if (vld) begin
      if (m_dropping) begin
        if (eof) m_dropping = 1'b0;
      end else if (m_in_frame || (sof && en)) begin
        if (!m_in_frame && m_occ >= D - 1) begin
          m_drops++;
          m_ovf++;
          if (!eof) m_dropping = 1'b1;
        end else if (m_occ == D - 2 && !eof) begin
          wr = 1'b1;
          e.last = 1'b1;
          e.user = {1'b1, sof};
          m_drops++;
          m_ovf++;
          m_in_frame = 1'b0;
          m_dropping = 1'b1;
        end else begin
          wr = 1'b1;
          m_in_frame = !eof;
        end
      end
    end
    if (wr) exp_q.push_back(e);
    m_occ = m_occ - int'(pop) + int'(wr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rdy);
  endtask

  task automatic clear_logs();
    act_q.delete();
    exp_q.delete();
    first_vld_cyc = -1;
    ovf_seen = 0;
    m_ovf = 0;
  endtask

  task automatic do_reset();
    pix_vld = 1'b0;
    pix_sof = 1'b0;
    pix_eol = 1'b0;
    pix_eof = 1'b0;
    tready  = 1'b0;
    rst_n   = 1'b0;
    m_occ = 0;
    m_in_frame = 1'b0;
    m_dropping = 1'b0;
    m_drops = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_logs();
    lerr_seen = 0;
    active_seen = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    do_reset();
    total++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b, want 0", tvalid); else passed++;
    total++; if (tlast !== 1'b0) $display("FAIL reset_tlast: got %b, want 0", tlast); else passed++;
    total++; if (tdata !== '0) $display("FAIL reset_tdata: got %h, want 0", tdata); else passed++;
    total++; if (tuser !== '0) $display("FAIL reset_tuser: got %b, want 0", tuser); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d, want 0", drop_cnt);
    else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, want 0", overflow);
    else passed++;
    total++; if (frame_active !== 1'b0) $display("FAIL reset_active: got %b, want 0", frame_active);
    else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL reset_len_err: got %b, want 0", len_err); else passed++;
  endtask

  task automatic test_basic_frame();
    int c0;
    clear_logs();
    c0 = cyc;
    for (int l = 0; l < 3; l++)
      for (int b = 0; b < 4; b++) drive(1'b1, l == 0 && b == 0, b == 3, l == 2 && b == 3, 1'b1, 1'b1);
    idle(6, 1'b1);
    total++; if (act_q.size() != 12) $display("FAIL basic_count: got %0d beats, want 12", act_q.size());
    else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d: got %h, want %h", i, act_q[i], exp_q[i]);
      else passed++;
    end
    for (int i = 0; i < act_q.size(); i++) begin
      total++;
      if (act_q[i].last !== (i % 4 == 3) || act_q[i].user !== ((i == 0) ? 2'b01 : 2'b00))
        $display("FAIL basic_flags%0d: got last=%b user=%b", i, act_q[i].last, act_q[i].user);
      else passed++;
    end
    total++;
    if (first_vld_cyc - c0 != 1) $display("FAIL basic_latency: got %0d cycles, want 1", first_vld_cyc - c0);
    else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL basic_drop_cnt: got %0d, want 0", drop_cnt);
    else passed++;
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int l = 0; l < 5; l++)
      for (int b = 0; b < 4; b++) drive(1'b1, l == 0 && b == 0, b == 3, l == 4 && b == 3, 1'b1, 1'b0);
    idle(3, 1'b0);
    total++; if (act_q.size() != 0) $display("FAIL ovf_stalled: got %0d beats, want 0", act_q.size());
    else passed++;
    total++; if (ovf_seen != 1) $display("FAIL ovf_pulses: got %0d, want 1", ovf_seen); else passed++;
    total++; if (drop_cnt !== 16'd1) $display("FAIL ovf_drop_cnt: got %0d, want 1", drop_cnt); else passed++;
    idle(25, 1'b1);
    total++; if (act_q.size() != 15) $display("FAIL ovf_drain: got %0d beats, want 15", act_q.size());
    else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) $display("FAIL ovf_beat%0d: got %h, want %h", i, act_q[i], exp_q[i]);
      else passed++;
    end
    if (act_q.size() == 15) begin
      total++;
      if (act_q[14].last !== 1'b1 || act_q[14].user[1] !== 1'b1)
        $display("FAIL ovf_trunc_beat: got last=%b user=%b, want 1/1x", act_q[14].last, act_q[14].user);
      else passed++;
    end
  endtask

  task automatic test_gating();
    clear_logs();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, i == 2, 1'b0, 1'b1, 1'b1);
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 3; b++) drive(1'b1, l == 0 && b == 0, b == 2, l == 1 && b == 2, 1'b0, 1'b1);
    idle(4, 1'b1);
    total++; if (act_q.size() != 0) $display("FAIL gate_blocked: got %0d beats, want 0", act_q.size());
    else passed++;
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 3; b++) drive(1'b1, l == 0 && b == 0, b == 2, l == 1 && b == 2, 1'b1, 1'b1);
    idle(4, 1'b1);
    total++; if (act_q.size() != 6) $display("FAIL gate_pass_count: got %0d, want 6", act_q.size());
    else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) $display("FAIL gate_beat%0d: got %h, want %h", i, act_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_single_beat();
    clear_logs();
    active_seen = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    total++; if (act_q.size() != 2) $display("FAIL single_count: got %0d, want 2", act_q.size());
    else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i] || act_q[i].last !== 1'b1 || act_q[i].user !== 2'b01)
        $display("FAIL single_beat%0d: got %h, want %h", i, act_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (active_seen) $display("FAIL single_active: got 1, want 0"); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    for (int b = 0; b < 5; b++) drive(1'b1, b == 0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (tvalid !== 1'b1) $display("FAIL midrst_pre_valid: got %b, want 1", tvalid); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %b, want 0", tvalid); else passed++;
    do_reset();
    idle(4, 1'b1);
    total++; if (act_q.size() != 0) $display("FAIL midrst_stale: got %0d beats, want 0", act_q.size());
    else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL midrst_drop_cnt: got %0d, want 0", drop_cnt);
    else passed++;
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 4; b++) drive(1'b1, l == 0 && b == 0, b == 3, l == 1 && b == 3, 1'b1, 1'b1);
    idle(4, 1'b1);
    total++; if (act_q.size() != 8) $display("FAIL midrst_next_count: got %0d, want 8", act_q.size());
    else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) $display("FAIL midrst_beat%0d: got %h, want %h", i, act_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_line_check();
    int exp_lerr;
    clear_logs();
    lerr_seen = 0;
    line_len = LW'(4);
    for (int b = 0; b < 3; b++) drive(1'b1, b == 0, b == 2, 1'b0, 1'b1, 1'b1);
    for (int b = 0; b < 4; b++) drive(1'b1, 1'b0, b == 3, b == 3, 1'b1, 1'b1);
    idle(4, 1'b1);
`ifdef SIF_FRAME_GATE_LINE_CHECK_EN
    exp_lerr = 1;
`else
    exp_lerr = 0;
`endif
    total++; if (lerr_seen != exp_lerr) $display("FAIL len_err_pulses: got %0d, want %0d", lerr_seen, exp_lerr);
    else passed++;
    total++; if (act_q.size() != 7) $display("FAIL len_data_count: got %0d, want 7", act_q.size());
    else passed++;
  endtask

  task automatic test_random();
    int  lines;
    int  bpl;
    bit  stall;
    bit  en;
    bit  rdy;
    clear_logs();
    for (int f = 0; f < 40; f++) begin
      lines = $urandom_range(1, 4);
      bpl   = $urandom_range(1, 6);
      stall = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
      for (int l = 0; l < lines; l++) begin
        for (int b = 0; b < bpl; b++) begin
          rdy = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
          drive(1'b1, l == 0 && b == 0, b == bpl - 1, l == lines - 1 && b == bpl - 1, en, rdy);
          if ($urandom_range(0, 4) == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, en, rdy);
        end
      end
    end
    idle(60, 1'b1);
    total++;
    if (act_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d beats, want %0d", act_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) $display("FAIL rand_beat%0d: got %h, want %h", i, act_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (ovf_seen != m_ovf) $display("FAIL rand_ovf: got %0d, want %0d", ovf_seen, m_ovf);
    else passed++;
    total++;
    if (drop_cnt !== 16'(m_drops)) $display("FAIL rand_drop_cnt: got %0d, want %0d", drop_cnt, m_drops);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_gating();
    test_single_beat();
    test_reset_mid_frame();
    test_line_check();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
